// File: rtl/inst_sequencer.sv
`timescale 1ns/1ps
// inst_sequencer: fetches consecutive program cache lines from host memory and
// dispatches their instruction words in order until HALT or the line limit.

module inst_sequencer_slot #(
    parameter int         INST_W  = 64,
    parameter logic [3:0] HALT_OP = 4'hF
) (
    input  logic [INST_W-1:0] word,
    output logic              halt
);
    assign halt = (word[INST_W-1 -: 4] == HALT_OP);
endmodule

module inst_sequencer #(
    parameter int         LINE_W    = 512,
    parameter int         INST_W    = 64,
    parameter int         ADDR_W    = 42,
    parameter int         MAX_LINES = 256,
    parameter logic [3:0] HALT_OP   = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              buf_addr_valid,
    input  logic [ADDR_W-1:0] buf_addr,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_req_ready,
    input  logic              rd_rsp_valid,
    input  logic [LINE_W-1:0] rd_rsp_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    input  logic              inst_ready,
    output logic              done,
    output logic              err,
    input  logic              done_ack,
    output logic [31:0]       inst_count
);
    localparam int IPL    = LINE_W / INST_W;
    localparam int SLOT_W = (IPL > 1) ? $clog2(IPL) : 1;
    localparam int LIDX_W = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    if (LINE_W % INST_W != 0) begin : g_bad_line
        $error("LINE_W must be a multiple of INST_W");
    end
    if (MAX_LINES < 1) begin : g_bad_max
        $error("MAX_LINES must be at least 1");
    end

    typedef enum logic [2:0] {
        WAIT_BUF,
        FCH_REQ,
        FCH_WAIT,
        EXECUTE,
        DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [ADDR_W-1:0]              base_q;
    logic [LIDX_W-1:0]              line_idx_q;
    logic [SLOT_W-1:0]              slot_q;
    logic [IPL-1:0][INST_W-1:0]     line_q;
    logic [31:0]                    count_q;
    logic                           err_q;
    logic [IPL-1:0]                 halt_vec;

    logic start, take, fire, set_err;
    logic cur_halt, last_slot, last_line;

    // Halt decode per slot, so the EXECUTE path is only a slot-indexed select.
    for (genvar g = 0; g < IPL; g++) begin : g_slot
        inst_sequencer_slot #(
            .INST_W (INST_W),
            .HALT_OP(HALT_OP)
        ) u_slot (
            .word(line_q[g]),
            .halt(halt_vec[g])
        );
    end

    assign cur_halt  = halt_vec[slot_q];
    assign last_slot = (slot_q == SLOT_W'(IPL - 1));
    assign last_line = (line_idx_q == LIDX_W'(MAX_LINES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WAIT_BUF;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        take    = 1'b0;
        fire    = 1'b0;
        set_err = 1'b0;
        case (state_q)
            WAIT_BUF: begin
                if (buf_addr_valid) begin
                    start   = 1'b1;
                    state_d = FCH_REQ;
                end
            end
            FCH_REQ: begin
                if (rd_req_ready) state_d = FCH_WAIT;
            end
            FCH_WAIT: begin
                if (rd_rsp_valid) begin
                    take    = 1'b1;
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                if (cur_halt) begin
                    state_d = DONE;
                end else if (inst_ready) begin
                    fire = 1'b1;
                    if (last_slot) begin
                        if (last_line) begin
                            set_err = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = FCH_REQ;
                        end
                    end
                end
            end
            DONE: begin
                if (done_ack) state_d = WAIT_BUF;
            end
            default: state_d = WAIT_BUF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q     <= '0;
            line_idx_q <= '0;
            slot_q     <= '0;
            line_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            if (start) begin
                base_q     <= buf_addr;
                line_idx_q <= '0;
                slot_q     <= '0;
                count_q    <= '0;
                err_q      <= 1'b0;
            end
            if (take) begin
                line_q <= rd_rsp_data;
                slot_q <= '0;
            end
            if (fire) begin
                count_q <= count_q + 32'd1;
                if (!last_slot)      slot_q     <= slot_q + SLOT_W'(1);
                else if (!last_line) line_idx_q <= line_idx_q + LIDX_W'(1);
            end
            if (set_err) err_q <= 1'b1;
        end
    end

    // Every output is a function of registered state only.
    assign rd_req_valid = (state_q == FCH_REQ);
    assign rd_req_addr  = base_q + ADDR_W'(line_idx_q);
    assign inst_valid   = (state_q == EXECUTE) && !cur_halt;
    assign inst         = line_q[slot_q];
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign inst_count   = count_q;

endmodule

// File: tb/tb_inst_sequencer.sv
`timescale 1ns/1ps
// Bench for inst_sequencer: table-driven programs, hand-written corner
// sequences, and randomized programs checked against a line/word model.
module tb_inst_sequencer;
    localparam int LINE_W    = 512;
    localparam int INST_W    = 64;
    localparam int ADDR_W    = 42;
    localparam int MAX_LINES = 2;
    localparam int IPL       = LINE_W / INST_W;

    typedef logic [ADDR_W-1:0] addr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              buf_addr_valid = 1'b0;
    addr_t             buf_addr = '0;
    logic              rd_req_valid;
    addr_t             rd_req_addr;
    logic              rd_req_ready;
    logic              rd_rsp_valid;
    logic [LINE_W-1:0] rd_rsp_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic              inst_ready;
    logic              done;
    logic              err;
    logic              done_ack = 1'b0;
    logic [31:0]       inst_count;

    always #5 clk = ~clk;

    inst_sequencer #(
        .LINE_W   (LINE_W),
        .INST_W   (INST_W),
        .ADDR_W   (ADDR_W),
        .MAX_LINES(MAX_LINES),
        .HALT_OP  (4'hF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .buf_addr_valid(buf_addr_valid),
        .buf_addr      (buf_addr),
        .rd_req_valid  (rd_req_valid),
        .rd_req_addr   (rd_req_addr),
        .rd_req_ready  (rd_req_ready),
        .rd_rsp_valid  (rd_rsp_valid),
        .rd_rsp_data   (rd_rsp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_ready    (inst_ready),
        .done          (done),
        .err           (err),
        .done_ack      (done_ack),
        .inst_count    (inst_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Host memory and reference model
    logic [LINE_W-1:0] mem [addr_t];
    addr_t             exp_reqs[$];
    logic [63:0]       exp_disp[$];
    bit                exp_err;

    task automatic model(input addr_t base);
        exp_reqs.delete();
        exp_disp.delete();
        exp_err = 1'b1;
        for (int l = 0; l < MAX_LINES && exp_err; l++) begin
            addr_t a;
            logic [LINE_W-1:0] d;
            a = base + addr_t'(l);
            d = mem.exists(a) ? mem[a] : '0;
            exp_reqs.push_back(a);
            for (int s = 0; s < IPL; s++) begin
                logic [63:0] w;
                w = d[s*INST_W +: INST_W];
                if (w[63:60] == 4'hF) begin
                    exp_err = 1'b0;
                    break;
                end
                exp_disp.push_back(w);
            end
        end
    endtask

    task automatic load_prog(input addr_t base, input int hl, input int hs);
        for (int l = 0; l < MAX_LINES; l++) begin
            logic [LINE_W-1:0] d;
            for (int s = 0; s < IPL; s++)
                d[s*INST_W +: INST_W] = (l == hl && s == hs) ? 64'hF000_0000_0000_0000
                                                              : 64'((l << 8) + s + 1);
            mem[base + addr_t'(l)] = d;
        end
    endtask

    // Memory responder / handshake monitor, all at negedge
    addr_t       got_reqs[$];
    logic [63:0] got_disp[$];
    int          ir_mode = 0, rr_mode = 0, rsp_delay = 2, stall_left = 0, req_stall_cycles = 0;
    bit          spur_exec = 0, spur_now = 0, toggle = 0;
    int          rsp_cnt = 0;
    addr_t       rsp_addr;
    bit          inst_held = 0, req_held = 0;
    logic [63:0] held_inst;
    addr_t       held_addr;

    initial begin
        inst_ready   = 1'b0;
        rd_req_ready = 1'b0;
        rd_rsp_valid = 1'b0;
        rd_rsp_data  = '0;
        forever begin
            @(negedge clk);
            rd_rsp_valid = 1'b0;
            if (rst_n) begin
                if (inst_held) begin
                    check("inst_hold_valid", 64'(inst_valid), 64'(1));
                    check("inst_hold_data", inst, held_inst);
                end
                if (req_held) begin
                    check("req_hold_valid", 64'(rd_req_valid), 64'(1));
                    check("req_hold_addr", 64'(rd_req_addr), 64'(held_addr));
                end
                case (ir_mode)
                    0:       inst_ready = 1'b1;
                    1:       begin toggle = !toggle; inst_ready = toggle; end
                    default: inst_ready = 1'($urandom_range(0, 1));
                endcase
                if (stall_left > 0 && rd_req_valid) begin
                    rd_req_ready = 1'b0;
                    stall_left--;
                end else if (rr_mode == 0) rd_req_ready = 1'b1;
                else rd_req_ready = 1'($urandom_range(0, 1));
                if (rd_req_valid && !rd_req_ready) req_stall_cycles++;
                inst_held = inst_valid && !inst_ready;
                held_inst = inst;
                req_held  = rd_req_valid && !rd_req_ready;
                held_addr = rd_req_addr;
                if (inst_valid && inst_ready) got_disp.push_back(inst);
                if (rd_req_valid && rd_req_ready) begin
                    got_reqs.push_back(rd_req_addr);
                    rsp_cnt  = rsp_delay;
                    rsp_addr = rd_req_addr;
                end else if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        rd_rsp_valid = 1'b1;
                        rd_rsp_data  = mem.exists(rsp_addr) ? mem[rsp_addr] : '0;
                    end
                end
                if (spur_exec && inst_valid && rsp_cnt == 0 && $urandom_range(0, 2) == 0) spur_now = 1;
            end else begin
                inst_held = 0;
                req_held  = 0;
            end
            if (spur_now && !rd_rsp_valid) begin
                rd_rsp_valid = 1'b1;
                rd_rsp_data  = {16{$urandom}};
                spur_now     = 0;
            end
        end
    end

    task automatic start_prog(input addr_t base);
        got_reqs.delete();
        got_disp.delete();
        buf_addr       = base;
        buf_addr_valid = 1'b1;
        @(negedge clk);
        buf_addr_valid = 1'b0;
        check("start_req_valid", 64'(rd_req_valid), 64'(1));
        check("start_req_addr", 64'(rd_req_addr), 64'(base));
    endtask

    task automatic finish_prog(input string tag, input int nreq, input int ndisp, input bit e, input bit noise);
        int cyc = 0;
        int n;
        while (!done && cyc < 3000) begin
            if (noise) begin
                done_ack       = 1'($urandom_range(0, 1));
                buf_addr       = addr_t'({$urandom, $urandom});
                buf_addr_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
        end
        done_ack       = 1'b0;
        buf_addr_valid = 1'b0;
        if (cyc >= 3000) begin
            check({tag, "_timeout"}, 64'(0), 64'(1));
            return;
        end
        check({tag, "_err"}, 64'(err), 64'(e));
        check({tag, "_model_err"}, 64'(err), 64'(exp_err));
        check({tag, "_count"}, 64'(inst_count), 64'(ndisp));
        check({tag, "_nreq"}, 64'(got_reqs.size()), 64'(nreq));
        check({tag, "_ndisp"}, 64'(got_disp.size()), 64'(exp_disp.size()));
        n = (got_reqs.size() < exp_reqs.size()) ? got_reqs.size() : exp_reqs.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_req%0d", tag, i), 64'(got_reqs[i]), 64'(exp_reqs[i]));
        n = (got_disp.size() < exp_disp.size()) ? got_disp.size() : exp_disp.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_disp%0d", tag, i), got_disp[i], exp_disp[i]);
        @(negedge clk);
        check({tag, "_done_hold"}, 64'(done), 64'(1));
        check({tag, "_count_hold"}, 64'(inst_count), 64'(ndisp));
    endtask

    task automatic ack();
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        check("done_fall", 64'(done), 64'(0));
    endtask

    typedef struct {
        addr_t base;
        int    hl;
        int    hs;
        int    ir;
        int    nreq;
        int    ndisp;
        bit    err;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{42'h100, 1, 0, 0, 2, 8, 1'b0};                // basic: HALT at line 1 slot 0
        vecs[1] = '{42'h300, -1, 0, 1, 2, 16, 1'b1};              // line limit under toggling ready
        vecs[2] = '{42'h3FF_FFFF_FFFF, 1, 5, 2, 2, 13, 1'b0};     // address wrap
        vecs[3] = '{42'h50, 0, 0, 0, 1, 0, 1'b0};                 // HALT in the first word
        vecs[4] = '{42'h60, 0, 7, 1, 1, 7, 1'b0};                 // HALT in the last slot

        #1;
        check("rst_req_valid", 64'(rd_req_valid), 64'(0));
        check("rst_req_addr", 64'(rd_req_addr), 64'(0));
        check("rst_inst_valid", 64'(inst_valid), 64'(0));
        check("rst_inst", inst, 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        check("rst_count", 64'(inst_count), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mem.delete();
            load_prog(vecs[i].base, vecs[i].hl, vecs[i].hs);
            ir_mode = vecs[i].ir;
            rr_mode = 0;
            rsp_delay = 2;
            model(vecs[i].base);
            start_prog(vecs[i].base);
            finish_prog($sformatf("vec%0d", i), vecs[i].nreq, vecs[i].ndisp, vecs[i].err, 1'b0);
            ack();
        end

        // Request stall: five cycles of rd_req_ready=0 on the first request
        ir_mode = 0;
        mem.delete();
        load_prog(42'h100, 1, 0);
        model(42'h100);
        req_stall_cycles = 0;
        stall_left = 5;
        start_prog(42'h100);
        finish_prog("stall", 2, 8, 1'b0, 1'b0);
        check("stall_cycles", 64'(req_stall_cycles), 64'(5));
        ack();

        // Spurious responses in WAIT_BUF, then during EXECUTE
        spur_now = 1;
        repeat (3) begin
            @(negedge clk);
            check("spur_idle_req", 64'(rd_req_valid), 64'(0));
            check("spur_idle_inst", 64'(inst_valid), 64'(0));
            check("spur_idle_done", 64'(done), 64'(0));
        end
        spur_exec = 1;
        ir_mode = 2;
        start_prog(42'h100);
        finish_prog("spur", 2, 8, 1'b0, 1'b0);
        spur_exec = 0;
        ack();

        // Reset while slot 3 is presented, then a late response
        begin
            int cyc = 0;
            ir_mode = 0;
            mem.delete();
            load_prog(42'h40, -1, 0);
            start_prog(42'h40);
            while (!(inst_valid && inst_count == 32'd3) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("rst_mid_reach", 64'(cyc < 200), 64'(1));
            rst_n = 1'b0;
            #1;
            check("rst_mid_req_valid", 64'(rd_req_valid), 64'(0));
            check("rst_mid_req_addr", 64'(rd_req_addr), 64'(0));
            check("rst_mid_inst_valid", 64'(inst_valid), 64'(0));
            check("rst_mid_inst", inst, 64'(0));
            check("rst_mid_done", 64'(done), 64'(0));
            check("rst_mid_err", 64'(err), 64'(0));
            check("rst_mid_count", 64'(inst_count), 64'(0));
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            spur_now = 1;
            repeat (4) begin
                @(negedge clk);
                check("post_rst_inst_valid", 64'(inst_valid), 64'(0));
                check("post_rst_req_valid", 64'(rd_req_valid), 64'(0));
                check("post_rst_done", 64'(done), 64'(0));
            end
        end

        // Restart from DONE with buf_addr_valid held and a new base
        mem.delete();
        load_prog(42'h100, 1, 0);
        load_prog(42'h200, 0, 4);
        model(42'h100);
        start_prog(42'h100);
        finish_prog("pre_restart", 2, 8, 1'b0, 1'b0);
        buf_addr = 42'h200;
        buf_addr_valid = 1'b1;
        @(negedge clk);
        check("restart_ignored_in_done", 64'(done), 64'(1));
        check("restart_ignored_no_req", 64'(rd_req_valid), 64'(0));
        model(42'h200);
        got_reqs.delete();
        got_disp.delete();
        done_ack = 1'b1;
        @(negedge clk);
        done_ack = 1'b0;
        check("restart_done_fall", 64'(done), 64'(0));
        check("restart_no_req_yet", 64'(rd_req_valid), 64'(0));
        @(negedge clk);
        buf_addr_valid = 1'b0;
        check("restart_req_valid", 64'(rd_req_valid), 64'(1));
        check("restart_req_addr", 64'(rd_req_addr), 64'(42'h200));
        check("restart_count_clr", 64'(inst_count), 64'(0));
        finish_prog("restart", 1, 4, 1'b0, 1'b0);
        ack();

        // Randomized programs against the model
        for (int it = 0; it < 40; it++) begin
            addr_t b;
            b = addr_t'({$urandom, $urandom});
            mem.delete();
            for (int l = 0; l < MAX_LINES; l++) begin
                logic [LINE_W-1:0] d;
                for (int s = 0; s < IPL; s++) d[s*INST_W +: INST_W] = {$urandom, $urandom};
                if ($urandom_range(0, 1) == 1)
                    d[$urandom_range(0, IPL-1)*INST_W + 60 +: 4] = 4'hF;
                mem[b + addr_t'(l)] = d;
            end
            ir_mode   = $urandom_range(0, 2);
            rr_mode   = $urandom_range(0, 1);
            rsp_delay = $urandom_range(1, 4);
            spur_exec = 1'($urandom_range(0, 1));
            model(b);
            start_prog(b);
            finish_prog($sformatf("rand%0d", it), exp_reqs.size(), exp_disp.size(), exp_err, 1'b1);
            spur_exec = 0;
            ack();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/inst_sequencer.md
Name: inst_sequencer

Overview:
- Parametrised fetch/dispatch controller placed between the host-memory read block and the execution datapath.
- On buffer-ready, fetches consecutive cache lines from the host buffer and splits each line into INSTS_PER_LINE instruction words.
- Dispatches words in order over a valid/ready handshake until a HALT opcode or the MAX_LINES limit, then reports done with status.

Parameters:
- LINE_W, 512, cache-line width in bits.
- INST_W, 64, instruction width in bits. LINE_W must be an integer multiple; INSTS_PER_LINE = LINE_W/INST_W.
- ADDR_W, 42, cache-line address width.
- MAX_LINES, 256, maximum lines fetched per program; must be ≥1.
- HALT_OP, 4'hF, opcode value that terminates the program; opcode = inst[INST_W-1 -: 4].

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- buf_addr_valid  in  1  host buffer address valid (level)
- buf_addr  in  ADDR_W  base line address of program buffer
- rd_req_valid  out  1  line read request
- rd_req_addr  out  ADDR_W  line address requested
- rd_req_ready  in  1  read request accepted
- rd_rsp_valid  in  1  read data returned (single-cycle pulse)
- rd_rsp_data  in  LINE_W  returned line
- inst_valid  out  1  instruction presented
- inst  out  INST_W  instruction word
- inst_ready  in  1  execution datapath accepts instruction
- done  out  1  program finished (level)
- err  out  1  finished by MAX_LINES without HALT; valid while done=1
- done_ack  in  1  return to idle
- inst_count  out  32  instructions dispatched since last start, wraps at 2^32

Behaviour:
- Reset (async, any state, including mid-fetch or mid-dispatch): state=WAIT_BUF; line_idx=0, slot=0, line buffer=0, inst_count=0. All outputs 0. A read response arriving after reset is ignored.
- No combinational path from any input to any output. All outputs derive from registered state, base address, line buffer, slot and line_idx.
- WAIT_BUF: on buf_addr_valid=1, latch buf_addr into base, clear line_idx/slot/inst_count, clear err. Next state FCH_REQ.
- FCH_REQ:
  - rd_req_valid=1; rd_req_addr=base+line_idx, modulo 2^ADDR_W.
  - Address is held stable until rd_req_ready=1; on that cycle, next state FCH_WAIT.
  - One outstanding request maximum.
- FCH_WAIT: rd_req_valid=0. On rd_rsp_valid=1, latch rd_rsp_data, slot=0, next state EXECUTE. rd_rsp_valid in any other state is ignored.
- EXECUTE:
  - Current word w = line[slot*INST_W +: INST_W]; inst=w.
  - If w's opcode==HALT_OP: inst_valid=0, the HALT word is not dispatched, next state DONE with err=0.
  - Otherwise inst_valid=1, and inst stays stable until handshake (inst_valid & inst_ready). On handshake, inst_count+=1, then:
    - slot<INSTS_PER_LINE-1: slot+=1, stay in EXECUTE. Next word presented the following cycle, so one word per cycle is possible.
    - slot==INSTS_PER_LINE-1 and line_idx==MAX_LINES-1: next state DONE, err=1.
    - otherwise: line_idx+=1, next state FCH_REQ.
  - A HALT in slot 0 of a line dispatches nothing from that line.
- DONE:
  - done=1; err held; inst_count held; inst_valid=0, rd_req_valid=0.
  - On done_ack=1, next state WAIT_BUF. done falls the next cycle.
  - buf_addr_valid still high in WAIT_BUF restarts immediately.
- done_ack outside DONE is ignored. buf_addr_valid outside WAIT_BUF is ignored; base is not re-latched.
- Latency:
  - buf_addr_valid to first rd_req_valid: 1 cycle.
  - rd_rsp_valid to first inst_valid: 1 cycle.
  - Last-slot handshake to next rd_req_valid: 1 cycle.

Test Plan:
- Basic program:
  - Stimulus: base=0x100, ready always 1, response 2 cycles after request. Line 0 holds 8 non-HALT words 0x1..0x8; line 1 slot 0 = 0xF000_0000_0000_0000.
  - Required: requests to 0x100 then 0x101; 8 instructions dispatched in order; done=1, err=0, inst_count=8.
- Backpressure:
  - Stimulus: inst_ready toggles 1/0 every cycle.
  - Required: inst stays stable while inst_ready=0; no word skipped or duplicated; order preserved.
- Line limit:
  - Stimulus: MAX_LINES=2, no HALT present.
  - Required: exactly 2 requests, 16 dispatches, done=1, err=1, inst_count=16.
- Request stall:
  - Stimulus: rd_req_ready held 0 for 5 cycles.
  - Required: rd_req_valid=1 with a constant address for all 5 cycles; exactly one request accepted.
  - Stimulus: spurious rd_rsp_valid injected in WAIT_BUF and EXECUTE.
  - Required: no effect on state or line buffer.
- Reset mid-dispatch:
  - Stimulus: rst_n asserted during EXECUTE slot 3.
  - Required: all outputs 0 immediately. After release, the sequencer waits for buf_addr_valid, and a late rd_rsp_valid is ignored.
- Restart:
  - Stimulus: done_ack in DONE with buf_addr_valid held 1 and a new base 0x200.
  - Required: first new request to 0x200 two cycles after done_ack; inst_count reset to 0.
